// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline (optional perf counters: PIPE_HAZARD_PERF_EN)
module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_br_taken,
    input  logic              ex_md_start,
    input  logic              md_done,
    input  logic              dmem_stall,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              ex_mem_flush,
    output logic              mem_wb_en,
    output logic              mem_wb_flush,
    output logic              md_busy,
    output logic              md_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Wait counter only needs to reach MD_TIMEOUT-1.
    localparam int               MD_CW   = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MD_CW-1:0] MD_LAST = MD_CW'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [MD_CW-1:0] md_cnt;
    logic [MD_CW-1:0] md_cnt_next;
    logic             load_use;
    logic             br_event;

    // Load-use match: the load still in EX produces a register ID wants now.
    always_comb begin
        load_use = 1'b0;
        if (ex_mem_read && (ex_rd != '0)) begin
            load_use = (id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd));
        end
    end

    // State register and md wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // Next-state and stage controls, resolved in priority order.
    always_comb begin
        state_next   = state;
        md_cnt_next  = md_cnt;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_en    = 1'b1;
        mem_wb_flush = 1'b0;
        md_timeout   = 1'b0;
        br_event     = 1'b0;

        if (dmem_stall) begin
            // Freeze everything, including the md wait bookkeeping.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if ((state == MD_WAIT) && !md_done) begin
            // Hold the front of the pipe while mul/div runs; drain WB with bubbles.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            if (md_cnt == MD_LAST) begin
                md_timeout  = 1'b1;
                state_next  = RUN;
                md_cnt_next = '0;
            end else begin
                md_cnt_next = md_cnt + 1'b1;
            end
        end else begin
            if (state == MD_WAIT) begin
                // md_done: release this cycle, back to RUN.
                state_next  = RUN;
                md_cnt_next = '0;
            end else if (ex_md_start) begin
                state_next  = MD_WAIT;
                md_cnt_next = '0;
            end

            if (ex_br_taken) begin
                // The ID instruction is being killed, so it cannot cause a stall.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                br_event    = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign md_busy = (state == MD_WAIT);

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Performance counters: cycles without PC advance and effective redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en) begin
                stall_q <= stall_q + 1'b1;
            end
            if (br_event) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    logic unused_perf;
    assign unused_perf = br_event;
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    // Stage control patterns: {pc, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, ex_mem_fl, mem_wb_en, mem_wb_fl}
    localparam logic [8:0] O_RUN = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] O_LU  = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] O_BR  = 9'b1_1_1_1_1_1_0_1_0;
    localparam logic [8:0] O_MD  = 9'b0_0_0_0_0_0_0_1_1;
    localparam logic [8:0] O_ST  = 9'b0_0_0_0_0_0_0_0_0;

`ifdef PIPE_HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken;
    logic       ex_md_start, md_done, dmem_stall;

    logic        a_pc, a_ife, a_iff, a_ide, a_idf, a_exe, a_exf, a_mwe, a_mwf, a_busy, a_to;
    logic        b_pc, b_ife, b_iff, b_ide, b_idf, b_exe, b_exf, b_mwe, b_mwf, b_busy, b_to;
    logic [31:0] a_stall, a_flush, b_stall, b_flush;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .MD_TIMEOUT(64), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
        .ex_md_start(ex_md_start), .md_done(md_done), .dmem_stall(dmem_stall),
        .pc_en(a_pc), .if_id_en(a_ife), .if_id_flush(a_iff), .id_ex_en(a_ide), .id_ex_flush(a_idf),
        .ex_mem_en(a_exe), .ex_mem_flush(a_exf), .mem_wb_en(a_mwe), .mem_wb_flush(a_mwf),
        .md_busy(a_busy), .md_timeout(a_to), .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .MD_TIMEOUT(4), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
        .ex_md_start(ex_md_start), .md_done(md_done), .dmem_stall(dmem_stall),
        .pc_en(b_pc), .if_id_en(b_ife), .if_id_flush(b_iff), .id_ex_en(b_ide), .id_ex_flush(b_idf),
        .ex_mem_en(b_exe), .ex_mem_flush(b_exf), .mem_wb_en(b_mwe), .mem_wb_flush(b_mwf),
        .md_busy(b_busy), .md_timeout(b_to), .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    wire [10:0] outs_a = {a_pc, a_ife, a_iff, a_ide, a_idf, a_exe, a_exf, a_mwe, a_mwf, a_busy, a_to};
    wire [10:0] outs_b = {b_pc, b_ife, b_iff, b_ide, b_idf, b_exe, b_exf, b_mwe, b_mwf, b_busy, b_to};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_a(input string tag, input logic [8:0] base, input logic busy, input logic to);
        chk(tag, 32'(outs_a), 32'({base, busy, to}));
    endtask

    task automatic chk_b(input string tag, input logic [8:0] base, input logic busy, input logic to);
        chk(tag, 32'(outs_b), 32'({base, busy, to}));
    endtask

    task automatic idle();
        rst = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_br_taken = 1'b0;
        ex_md_start = 1'b0; md_done = 1'b0; dmem_stall = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    task automatic reset_dut();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        reset_dut();

        // Reset state
        cyc(); #1;
        chk_a("reset_a", O_RUN, 1'b0, 1'b0);
        chk_b("reset_b", O_RUN, 1'b0, 1'b0);
        chk("reset_stall_cnt", a_stall, 32'd0);
        chk("reset_flush_cnt", a_flush, 32'd0);

        // Load-use via rs1, then the bubble cycle no longer matches
        cyc(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; #1;
        chk_a("lu_rs1", O_LU, 1'b0, 1'b0);
        cyc(); ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; #1;
        chk_a("lu_after", O_RUN, 1'b0, 1'b0);
        // Load-use via rs2
        cyc(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1; #1;
        chk_a("lu_rs2", O_LU, 1'b0, 1'b0);
        // Matching but unused rs1 does not stall
        cyc(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b0;
        id_rs2 = 5'd4; id_use_rs2 = 1'b1; #1;
        chk_a("lu_unused", O_RUN, 1'b0, 1'b0);
        // Load to x0 never stalls
        cyc(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        id_rs2 = 5'd0; id_use_rs2 = 1'b1; #1;
        chk_a("lu_x0", O_RUN, 1'b0, 1'b0);
        // Branch overrides load-use
        cyc(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_br_taken = 1'b1; #1;
        chk_a("br_over_lu", O_BR, 1'b0, 1'b0);
        cyc(); ex_br_taken = 1'b1; #1;
        chk_a("br_alone", O_BR, 1'b0, 1'b0);

        // Mul/div with md_done five cycles after start
        reset_dut();
        cyc(); ex_md_start = 1'b1; #1;
        chk_a("md_start", O_RUN, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (i == 2) begin
                ex_br_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
            end
            #1;
            chk_a($sformatf("md_hold_%0d", i), O_MD, 1'b1, 1'b0);
        end
        cyc(); md_done = 1'b1; #1;
        chk_a("md_done", O_RUN, 1'b1, 1'b0);
        cyc(); md_done = 1'b1; #1;
        chk_a("md_done_in_run", O_RUN, 1'b0, 1'b0);
        cyc(); #1;
        chk_a("md_after", O_RUN, 1'b0, 1'b0);

        // Reset in the middle of a wait
        cyc(); ex_md_start = 1'b1; #1;
        cyc(); #1;
        chk_a("md_hold_pre_rst", O_MD, 1'b1, 1'b0);
        cyc(); rst = 1'b1;
        cyc(); #1;
        chk_a("rst_mid_wait", O_RUN, 1'b0, 1'b0);
        cyc(); md_done = 1'b1; #1;
        chk_a("done_after_rst", O_RUN, 1'b0, 1'b0);

        // Timeout on the MD_TIMEOUT=4 instance
        reset_dut();
        cyc(); ex_md_start = 1'b1; #1;
        chk_b("to_start", O_RUN, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            cyc(); #1;
            chk_b($sformatf("to_hold_%0d", i), O_MD, 1'b1, 1'b0);
        end
        cyc(); #1;
        chk_b("to_pulse", O_MD, 1'b1, 1'b1);
        cyc(); #1;
        chk_b("to_exit", O_RUN, 1'b0, 1'b0);

        // md_done on the timeout cycle wins
        reset_dut();
        cyc(); ex_md_start = 1'b1; #1;
        for (int i = 1; i <= 3; i++) begin
            cyc(); #1;
        end
        cyc(); md_done = 1'b1; #1;
        chk_b("done_beats_to", O_RUN, 1'b1, 1'b0);
        cyc(); #1;
        chk_b("done_beats_to_exit", O_RUN, 1'b0, 1'b0);

        // dmem_stall during MD_WAIT freezes the wait counter
        reset_dut();
        cyc(); ex_md_start = 1'b1; #1;
        chk("perf_stall_zero", a_stall, 32'd0);
        chk("perf_flush_zero", a_flush, 32'd0);
        cyc(); #1;
        chk_a("st_hold_1", O_MD, 1'b1, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            cyc(); dmem_stall = 1'b1; #1;
            chk_a($sformatf("st_frozen_a_%0d", i), O_ST, 1'b1, 1'b0);
            chk_b($sformatf("st_frozen_b_%0d", i), O_ST, 1'b1, 1'b0);
        end
        cyc(); #1;
        chk_b("st_b_hold_5", O_MD, 1'b1, 1'b0);
        cyc(); #1;
        chk_b("st_b_hold_6", O_MD, 1'b1, 1'b0);
        cyc(); #1;
        chk_a("st_a_hold_7", O_MD, 1'b1, 1'b0);
        chk_b("st_b_timeout", O_MD, 1'b1, 1'b1);
        cyc(); md_done = 1'b1; #1;
        chk_a("st_a_done", O_RUN, 1'b1, 1'b0);
        chk_b("st_b_done_ignored", O_RUN, 1'b0, 1'b0);
        cyc(); ex_br_taken = 1'b1; #1;
        chk_a("st_br", O_BR, 1'b0, 1'b0);
        chk("perf_stall_7", a_stall, 32'(PERF * 7));
        chk("perf_stall_b_7", b_stall, 32'(PERF * 7));
        chk("perf_flush_0", a_flush, 32'd0);
        cyc(); ex_br_taken = 1'b1; dmem_stall = 1'b1; #1;
        chk_a("st_br_masked", O_ST, 1'b0, 1'b0);
        cyc(); #1;
        chk_a("st_final", O_RUN, 1'b0, 1'b0);
        chk("perf_stall_8", a_stall, 32'(PERF * 8));
        chk("perf_flush_1", a_flush, 32'(PERF * 1));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
